instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer side of the instruction memory: receives a byte-serial program image and writes it into instruction memory one 32-bit word at a time.
- Sits between the boot/debug byte link and the instruction memory write port, and is active while the core is held off.
- Image format: 2-byte big-endian word count N, then N words, each sent as 4 bytes, little-endian.

Parameters:
- ADDR_WIDTH, 22, instruction memory word-address width.
- BASE_ADDR, 0, word address written by the first word of every image.
- LEN_WIDTH, 16, width of the word-count header; fixed at 2 header bytes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- byteIn  input  8  incoming image byte.
- byteValid  input  1  byteIn holds a valid byte.
- byteReady  output  1  loader accepts a byte this cycle.
- wrEn  output  1  instruction memory write strobe, one cycle per word.
- wrAddr  output  ADDR_WIDTH  word address for the write.
- wrData  output  32  assembled word.
- busy  output  1  high from the first accepted header byte until the done cycle, inclusive.
- done  output  1  one-cycle pulse when an image completes.
- err  output  1  checksum mismatch flag; sticky until the next image starts.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HDR0.
  - byteReady=0, wrEn=0, wrAddr=BASE_ADDR, wrData=0, busy=0, done=0, err=0.
  - byte-lane counter and word counter cleared.
- Byte transfer: a byte transfers on a rising edge with byteValid=1 and byteReady=1. byteIn is ignored otherwise.
- byteReady is a registered state decode:
  - high in HDR0, HDR1, DATA (and CSUM when that feature is compiled in).
  - low in WRITE and DONE.
  - high in the first cycle after reset deasserts.
- HDR0: accept byte into count[15:8]. busy goes high, err clears, wrAddr<=BASE_ADDR. Go to HDR1.
- HDR1: accept byte into count[7:0].
  - If the resulting count is 0: go to DONE (or CSUM when enabled).
  - Otherwise: go to DATA with lane=0.
- DATA: accept byte into wrData[8*lane+7:8*lane], then lane++. When the 4th byte (lane 3) is accepted, go to WRITE.
- WRITE: exactly one cycle.
  - wrEn=1, wrAddr and wrData stable; the memory latches them on this cycle.
  - Next cycle: wrAddr increments by 1 and the word counter decrements.
  - If remaining words = 0: go to DONE (or CSUM). Otherwise: go to DATA with lane=0.
- DONE: one cycle with done=1 and busy=1. Next cycle: HDR0, busy=0.
- Latency: a word's wrEn asserts in the cycle directly after its 4th byte is accepted. Minimum image time is 2 + 5N + 1 cycles.
- Address wrap: wrAddr increments modulo 2^ADDR_WIDTH. 2^ADDR_WIDTH-1 wraps to 0 without error.
- Stalls: byteValid=0 holds state indefinitely, and a partial word is retained. There is no timeout.
- wrEn is never high outside WRITE. wrData and wrAddr hold their values between writes.
- Reset mid-image: any partial word is discarded and no wrEn is issued. The loader restarts at HDR0 and busy drops immediately.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A running XOR of every data byte (header excluded) is cleared in HDR0.
  - After the last WRITE (or after HDR1 when N=0), state CSUM accepts one checksum byte.
  - If that byte differs from the running XOR, err<=1, registered in the same transition into DONE, so err is high during the done cycle.
  - Words already written are not rolled back.
- Without the macro: there is no CSUM state, no checksum byte is consumed, and err is tied to 0.

Test Plan:
- Reset: hold reset=0 with byteValid=1 -> byteReady=0, wrEn=0, busy=0, done=0. Release reset -> byteReady=1 on the next cycle.
- Single word: bytes 00 01 78 56 34 12 with byteValid held high -> one wrEn pulse with wrAddr=BASE_ADDR and wrData=0x12345678 in the cycle after byte 0x12, then done one cycle later, then busy=0.
- Three words with gaps: count 00 03, byteValid dropped for 2 cycles mid-word -> writes at BASE, BASE+1, BASE+2 with the correct words, byteReady=0 during each WRITE cycle, and done exactly once.
- Zero length: bytes 00 00 -> no wrEn, and done pulses the cycle after HDR1 (CSUM byte 00 expected when enabled).
- Wrap: BASE_ADDR=22'h3FFFFF, count 2 -> writes at 0x3FFFFF then 0x000000.
- Checksum (macro on): image 00 01 11 22 33 44 followed by 0x44 -> err=0. The same image followed by 0x45 -> err=1 in the done cycle, holding until the next HDR0 byte.

Source files
------------

// File: rtl/instr_loader_if.sv
// Byte-link and instruction-memory write bundle for instr_loader.
// slave = the loader itself, master = the byte source / memory side.
interface instr_loader_if #(
  parameter int unsigned ADDR_WIDTH = 22
);
  logic [7:0]            byteIn;
  logic                  byteValid;
  logic                  byteReady;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [31:0]           wrData;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output byteIn, byteValid,
    input  byteReady, wrEn, wrAddr, wrData, busy, done, err
  );

  modport slave (
    input  byteIn, byteValid,
    output byteReady, wrEn, wrAddr, wrData, busy, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// Byte-serial program image loader: 2-byte BE word count, then LE 32-bit words.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// HDR0  | idle / waiting for count[15:8]
// HDR1  | waiting for count[7:0]
// DATA  | collecting the 4 bytes of a word
// WRITE | one-cycle memory write strobe
// CSUM  | waiting for checksum byte (checksum build only)
// DONE  | one-cycle completion pulse
module instr_loader #(
  parameter int unsigned           ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           LEN_WIDTH  = 16
) (
  input logic           clk,
  input logic           reset,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE
`ifdef INSTR_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CSUM;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  hdr_count;
  logic [1:0]            lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  err_q, err_d;
`endif

  assign accept    = bus.byteValid & ready_q;
  assign hdr_count = {count_q[LEN_WIDTH-1:8], bus.byteIn};
  // Ready is registered from the next state, so it is low the whole WRITE/DONE cycle.
  assign ready_d   = (state_d != S_WRITE) && (state_d != S_DONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d = {bus.byteIn, 8'h00};
          addr_d  = BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
          err_d   = 1'b0;
`endif
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          lane_d  = 2'd0;
          state_d = (hdr_count == '0) ? S_LAST : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d[{lane_q, 3'b000} +: 8] = bus.byteIn;
          lane_d = lane_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byteIn;
`endif
          if (lane_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_q - LEN_WIDTH'(1);
        lane_d  = 2'd0;
        state_d = (count_q == LEN_WIDTH'(1)) ? S_LAST : S_DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          err_d   = err_q | (bus.byteIn != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HDR0;
      ready_q <= 1'b0;
      count_q <= '0;
      lane_q  <= 2'd0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.byteReady = ready_q;
  assign bus.wrEn      = (state_q == S_WRITE);
  assign bus.wrAddr    = addr_q;
  assign bus.wrData    = data_q;
  assign bus.busy      = (state_q != S_HDR0);
  assign bus.done      = (state_q == S_DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: cycle table for a single-word image, then directed
// sequences for gaps, zero length, address wrap, mid-image reset and checksum.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;

  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_WIDTH(22)) if0 ();
  instr_loader_if #(.ADDR_WIDTH(22)) if1 ();

  assign if0.byteIn    = byte_in;
  assign if0.byteValid = byte_valid;
  assign if1.byteIn    = byte_in;
  assign if1.byteValid = byte_valid;

  instr_loader #(.ADDR_WIDTH(22), .BASE_ADDR(22'h000000), .LEN_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  instr_loader #(.ADDR_WIDTH(22), .BASE_ADDR(22'h3FFFFF), .LEN_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        rdy;
    logic        we;
    logic [21:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  int          errors = 0;
  int          checks = 0;
  logic [21:0] wa0[$], wa1[$];
  logic [31:0] wd0[$], wd1[$];
  int          done_cnt0 = 0;
  logic [7:0]  xr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rdy,
                              input logic we, input logic [21:0] addr, input logic [31:0] data,
                              input logic busy, input logic done, input logic err);
    vec_t r;
    r.v = v; r.b = b; r.rdy = rdy; r.we = we; r.addr = addr;
    r.data = data; r.busy = busy; r.done = done; r.err = err;
    return r;
  endfunction

  // Write logger; byteReady must be low whenever a write strobe is up.
  always @(negedge clk) begin
    if (if0.wrEn) begin
      wa0.push_back(if0.wrAddr);
      wd0.push_back(if0.wrData);
      chk("ready low in WRITE dut0", 32'(if0.byteReady), 32'd0);
    end
    if (if1.wrEn) begin
      wa1.push_back(if1.wrAddr);
      wd1.push_back(if1.wrData);
      chk("ready low in WRITE dut1", 32'(if1.byteReady), 32'd0);
    end
    if (if0.done) done_cnt0++;
  end

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    done_cnt0 = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!if0.byteReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_byte ready timeout", 32'(n), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    xr = 8'h00;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      xr = xr ^ w[8*i +: 8];
    end
  endtask

  task automatic wait_done(input string name, input logic exp_err);
    int n = 0;
    while (!if0.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done seen"}, 32'(if0.done), 32'd1);
    chk({name, " busy in done"}, 32'(if0.busy), 32'd1);
    chk({name, " err in done"}, 32'(if0.err), 32'(exp_err));
    @(negedge clk);
    chk({name, " done cleared"}, 32'(if0.done), 32'd0);
    chk({name, " busy cleared"}, 32'(if0.busy), 32'd0);
  endtask

  task automatic end_image(input string name);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(xr);
`endif
    wait_done(name, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single-word image, cycle by cycle; bytes offered during WRITE/DONE must be ignored.
    tbl.push_back(mk(1, 8'h00, 1, 0, 22'h0, 32'h00000000, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 1, 0, 22'h0, 32'h00000000, 1, 0, 0));
    tbl.push_back(mk(1, 8'h78, 1, 0, 22'h0, 32'h00000000, 1, 0, 0));
    tbl.push_back(mk(1, 8'h56, 1, 0, 22'h0, 32'h00000078, 1, 0, 0));
    tbl.push_back(mk(1, 8'h34, 1, 0, 22'h0, 32'h00005678, 1, 0, 0));
    tbl.push_back(mk(1, 8'h12, 1, 0, 22'h0, 32'h00345678, 1, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 1, 22'h0, 32'h12345678, 1, 0, 0));
`ifdef INSTR_LOADER_CHECKSUM_EN
    tbl.push_back(mk(1, 8'h08, 1, 0, 22'h1, 32'h12345678, 1, 0, 0));
`endif
    tbl.push_back(mk(1, 8'hBB, 0, 0, 22'h1, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 22'h1, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 22'h1, 32'h12345678, 0, 0, 0));

    reset = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(if0.byteReady), 32'd0);
    chk("reset wrEn", 32'(if0.wrEn), 32'd0);
    chk("reset busy", 32'(if0.busy), 32'd0);
    chk("reset done", 32'(if0.done), 32'd0);
    chk("reset err", 32'(if0.err), 32'd0);
    chk("reset wrAddr", 32'(if0.wrAddr), 32'h0);
    chk("reset wrData", 32'(if0.wrData), 32'h0);
    chk("reset wrAddr dut1", 32'(if1.wrAddr), 32'h3FFFFF);
    reset = 1'b1;
    @(negedge clk);
    chk("ready after release", 32'(if0.byteReady), 32'd1);
    chk("busy after release", 32'(if0.busy), 32'd0);

    clear_logs();
    for (int i = 0; i < tbl.size(); i++) begin
      byte_valid = tbl[i].v;
      byte_in    = tbl[i].b;
      chk($sformatf("vec%0d ready", i), 32'(if0.byteReady), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d wrEn", i), 32'(if0.wrEn), 32'(tbl[i].we));
      chk($sformatf("vec%0d wrAddr", i), 32'(if0.wrAddr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d wrData", i), if0.wrData, tbl[i].data);
      chk($sformatf("vec%0d busy", i), 32'(if0.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d done", i), 32'(if0.done), 32'(tbl[i].done));
      chk($sformatf("vec%0d err", i), 32'(if0.err), 32'(tbl[i].err));
      @(negedge clk);
    end
    chk("single writes", 32'(wa0.size()), 32'd1);
    chk("single done count", 32'(done_cnt0), 32'd1);
    if (wa1.size() == 1) chk("single addr dut1", 32'(wa1[0]), 32'h3FFFFF);
    else chk("single writes dut1", 32'(wa1.size()), 32'd1);

    // Three words with a 2-cycle stall in the middle of word 2.
    clear_logs();
    send_hdr(16'd3);
    send_word(32'hA1B2C3D4);
    send_byte(8'h04); xr = xr ^ 8'h04;
    send_byte(8'h03); xr = xr ^ 8'h03;
    repeat (2) @(negedge clk);
    chk("stall partial word", if0.wrData, 32'hA1B20304);
    chk("stall ready", 32'(if0.byteReady), 32'd1);
    chk("stall busy", 32'(if0.busy), 32'd1);
    send_byte(8'h02); xr = xr ^ 8'h02;
    send_byte(8'h01); xr = xr ^ 8'h01;
    send_word(32'hDEADBEEF);
    end_image("three");
    chk("three writes", 32'(wa0.size()), 32'd3);
    chk("three done count", 32'(done_cnt0), 32'd1);
    if (wa0.size() == 3) begin
      chk("three addr0", 32'(wa0[0]), 32'h0);
      chk("three addr1", 32'(wa0[1]), 32'h1);
      chk("three addr2", 32'(wa0[2]), 32'h2);
      chk("three data0", wd0[0], 32'hA1B2C3D4);
      chk("three data1", wd0[1], 32'h01020304);
      chk("three data2", wd0[2], 32'hDEADBEEF);
    end
    if (wa1.size() == 3) begin
      chk("three wrap addr0", 32'(wa1[0]), 32'h3FFFFF);
      chk("three wrap addr1", 32'(wa1[1]), 32'h000000);
      chk("three wrap addr2", 32'(wa1[2]), 32'h000001);
    end else chk("three writes dut1", 32'(wa1.size()), 32'd3);

    // Zero-length image.
    clear_logs();
    send_hdr(16'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("zero csum ready", 32'(if0.byteReady), 32'd1);
    send_byte(8'h00);
`endif
    chk("zero done next cycle", 32'(if0.done), 32'd1);
    wait_done("zero", 1'b0);
    chk("zero writes", 32'(wa0.size()), 32'd0);

    // Count 2: dut1 wraps from the top of the address space.
    clear_logs();
    send_hdr(16'd2);
    send_word(32'h11111111);
    send_word(32'h22222222);
    end_image("wrap");
    if (wa1.size() == 2) begin
      chk("wrap addr0", 32'(wa1[0]), 32'h3FFFFF);
      chk("wrap addr1", 32'(wa1[1]), 32'h000000);
      chk("wrap data1", wd1[1], 32'h22222222);
    end else chk("wrap writes dut1", 32'(wa1.size()), 32'd2);
    chk("wrap final addr dut1", 32'(if1.wrAddr), 32'h000001);

    // Reset in the middle of a word: no write, busy drops at once.
    clear_logs();
    send_hdr(16'd2);
    send_byte(8'hD4);
    send_byte(8'hC3);
    send_byte(8'hB2);
    #2 reset = 1'b0;
    #1;
    chk("midreset busy", 32'(if0.busy), 32'd0);
    chk("midreset ready", 32'(if0.byteReady), 32'd0);
    chk("midreset wrData", if0.wrData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset ready back", 32'(if0.byteReady), 32'd1);
    chk("midreset writes", 32'(wa0.size()), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    clear_logs();
    send_hdr(16'd1);
    send_word(32'h44332211);
    chk("csum model", 32'(xr), 32'h44);
    send_byte(8'h44);
    wait_done("csum good", 1'b0);
    send_hdr(16'd1);
    send_word(32'h44332211);
    send_byte(8'h45);
    wait_done("csum bad", 1'b1);
    chk("csum err sticky", 32'(if0.err), 32'd1);
    send_byte(8'h00);
    chk("csum err cleared", 32'(if0.err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done("csum clear", 1'b0);
    chk("csum writes", 32'(wa0.size()), 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
